// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer: owns the state register, round counter and in/out handshakes; optional abort port under AES_CTRL_ABORT_EN.
// Latency NR+1 cycles from accept to out_valid; one block in flight, result held in DONE until out_ready, in_ready low while busy.
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
`ifdef AES_CTRL_ABORT_EN
    input  logic          abort,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic [RW-1:0] rk_idx,
    input  logic [127:0]  rk_data,
    output logic [127:0]  rd_state,
    output logic          rd_final,
    input  logic [127:0]  rd_result,
    output logic          busy
);

    generate
        if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
            $error("aes_round_ctrl: NR must be 10, 12 or 14");
        end
        if ((2 ** RW) <= NR) begin : g_bad_rw
            $error("aes_round_ctrl: RW too narrow to hold NR");
        end
    endgenerate

    localparam logic [RW-1:0] LAST_RND = RW'(NR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [127:0]  state_q, state_d;
    logic [RW-1:0] rnd_q, rnd_d;
    logic          abort_w;

`ifdef AES_CTRL_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    // rk_data and rd_result are only read in the branch that captures them,
    // so unknowns on those buses outside those cycles never reach state_q.
    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        rnd_d     = rnd_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        rk_idx    = '0;
        rd_final  = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = in_data ^ rk_data;
                    rnd_d   = RW'(1);
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                rk_idx   = rnd_q;
                rd_final = (rnd_q == LAST_RND);
                state_d  = rd_result;
                if (rnd_q == LAST_RND) begin
                    fsm_d = DONE;
                end else begin
                    rnd_d = rnd_q + RW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = state_q;
                if (out_ready) begin
                    fsm_d = IDLE;
                    rnd_d = '0;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
        // Abort wins over delivery: a block in DONE is dropped, not handed out.
        if (abort_w && fsm_q != IDLE) begin
            fsm_d   = IDLE;
            state_d = '0;
            rnd_d   = '0;
        end
    end

    assign rd_state = state_q;
    assign busy     = (fsm_q != IDLE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: AES datapath and key store modelled here, cycle-level behavioural model checked every cycle.
module tb_aes_round_ctrl;
    localparam int NR = 10;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         abort = 1'b0, abort14 = 1'b0;
    logic         in_valid = 1'b0, in_ready, out_valid, out_ready, rd_final, busy;
    logic [127:0] in_data = '0, out_data, rk_data, rd_state, rd_result;
    logic [3:0]   rk_idx;
    logic         iv14 = 1'b0, ir14, ov14, or14 = 1'b1, rdf14, busy14;
    logic [127:0] id14 = '0, od14, rkd14, rds14, rdr14;
    logic [3:0]   rki14;

    aes_round_ctrl #(.NR(10), .RW(4)) dut (
        .clk(clk), .rst(rst),
`ifdef AES_CTRL_ABORT_EN
        .abort(abort),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rk_idx(rk_idx), .rk_data(rk_data), .rd_state(rd_state),
        .rd_final(rd_final), .rd_result(rd_result), .busy(busy)
    );

    aes_round_ctrl #(.NR(14), .RW(4)) dut14 (
        .clk(clk), .rst(rst),
`ifdef AES_CTRL_ABORT_EN
        .abort(abort14),
`endif
        .in_valid(iv14), .in_ready(ir14), .in_data(id14),
        .out_valid(ov14), .out_ready(or14), .out_data(od14),
        .rk_idx(rki14), .rk_data(rkd14), .rd_state(rds14),
        .rd_final(rdf14), .rd_result(rdr14), .busy(busy14)
    );

    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out", nm);
    endtask

    // ---------------- AES reference arithmetic ----------------
    logic [7:0]   sb [0:255];
    logic [127:0] rk_a [0:15];
    logic [127:0] rk_b [0:15];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input bit fin);
        logic [7:0] b [0:15];
        logic [7:0] t [0:15];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sb[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nr, input bit sel);
        logic [31:0] w [0:63];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            if (sel) rk_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else     rk_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input bit sel, input int nr);
        logic [127:0] s;
        s = pt ^ (sel ? rk_b[0] : rk_a[0]);
        for (int r = 1; r <= nr; r++) s = aes_round(s, sel ? rk_b[r] : rk_a[r], r == nr);
        return s;
    endfunction

    // Combinational key store and round datapath seen by each DUT
    always_comb rk_data   = rk_a[rk_idx];
    always_comb rd_result = aes_round(rd_state, rk_data, rd_final);
    always_comb rkd14     = rk_b[rki14];
    always_comb rdr14     = aes_round(rds14, rkd14, rdf14);

    // ---------------- cycle-level behavioural model (NR=10 instance) ----------------
    bit           have = 1'b0;
    int           age = 0, cyc = 0, acc_cnt = 0, hs_cnt = 0, acc_cyc = 0, hs_cyc = 0;
    logic [127:0] st = '0, exp_ct = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            have = 1'b0; age = 0; st = '0;
        end else begin
            if (have) begin
                if (abort) begin
                    have = 1'b0; age = 0; st = '0;
                end else if (age > NR) begin
                    if (out_ready) begin
                        have = 1'b0; hs_cnt++; hs_cyc = cyc;
                    end
                end else begin
                    st = aes_round(st, rk_a[age], age == NR);
                    age++;
                end
            end else if (in_valid) begin
                have = 1'b1; age = 1;
                st = in_data ^ rk_a[0];
                exp_ct = encrypt(in_data, 1'b0, NR);
                acc_cnt++; acc_cyc = cyc;
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("in_ready",  128'(in_ready),  128'(!have));
                chk("out_valid", 128'(out_valid), 128'(have && age > NR));
                chk("busy",      128'(busy),      128'(have));
                chk("rk_idx",    128'(rk_idx),    (have && age <= NR) ? 128'(age) : 128'(0));
                chk("rd_final",  128'(rd_final),  128'(have && age == NR));
                chk("rd_state",  rd_state,        st);
                if (have && age > NR) chk("out_data", out_data, exp_ct);
            end
        end
    end

    // out_ready driver: 0 = hold low, 1 = hold high, 2 = random
    int or_mode = 0;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [127:0] pt);
        int a0;
        bit ok;
        a0 = acc_cnt; ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = pt;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #1;
            if (acc_cnt != a0) ok = 1'b1;
        end
        if (!ok) timeout("send_accept");
    endtask

    task automatic wait_age(input int a);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (have && age == a) ok = 1'b1;
        end
        if (!ok) timeout("wait_round");
    endtask

    task automatic wait_out();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        if (!ok) timeout("wait_out_valid");
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (!have) ok = 1'b1;
        end
        if (!ok) timeout("wait_idle");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0]   inv;
        logic [127:0] pt2;
        int           lat, h0, a0;
        bit           ok;

        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            for (int j = 1; j < 256; j++)
                if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
            sb[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        expand(C1_KEY, 4, 10, 1'b0);
        expand(C3_KEY, 8, 14, 1'b1);

        // Pin the reference model to published values
        chk("model_sbox_00", 128'(sb[0]), 128'h63);
        chk("model_sbox_53", 128'(sb[8'h53]), 128'hed);
        chk("model_rk10", rk_a[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("model_c1", encrypt(C1_PT, 1'b0, 10), C1_CT);
        chk("model_c3", encrypt(C1_PT, 1'b1, 14), C3_CT);

        #2;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy",      128'(busy),      128'(0));
        chk("rst_rk_idx",    128'(rk_idx),    128'(0));
        chk("rst_rd_final",  128'(rd_final),  128'(0));
        chk("rst_out_data",  out_data,        128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(1));

        // NR=14 instance, FIPS-197 C.3
        iv14 = 1'b1; id14 = C1_PT;
        @(posedge clk); #1;
        lat = 1; ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            iv14 = 1'b0;
            if (ov14) ok = 1'b1;
            else begin
                @(posedge clk); lat++;
            end
        end
        if (!ok) timeout("c3_out_valid");
        chk("c3_latency", 128'(lat), 128'(15));
        chk("c3_ct", od14, C3_CT);

        // FIPS-197 C.1 with latency, then backpressure in DONE
        or_mode = 0;
        send(C1_PT);
        in_valid = 1'b0;
        wait_out();
        lat = cyc - acc_cyc;
        chk("c1_latency", 128'(lat), 128'(11));
        chk("c1_ct", out_data, C1_CT);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
        end
        chk("bp_data", out_data, C1_CT);
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        in_valid = 1'b0;
        h0 = hs_cnt;
        or_mode = 1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_one_transfer", 128'(hs_cnt - h0), 128'(1));
        chk("bp_in_ready_after", 128'(in_ready), 128'(1));

        // Back-to-back with in_valid held high
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        send(C1_PT);
        send(pt2);
        chk("b2b_gap", 128'(acc_cyc - hs_cyc), 128'(1));
        in_valid = 1'b0;
        wait_out();
        chk("b2b_second_ct", out_data, encrypt(pt2, 1'b0, 10));
        wait_idle();

        // Asynchronous reset in round 5
        send({$urandom, $urandom, $urandom, $urandom});
        in_valid = 1'b0;
        wait_age(5);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_busy",      128'(busy),      128'(0));
        chk("arst_rk_idx",    128'(rk_idx),    128'(0));
        chk("arst_rd_final",  128'(rd_final),  128'(0));
        chk("arst_rd_state",  rd_state,        128'(0));
        chk("arst_out_data",  out_data,        128'(0));
        @(negedge clk);
        #2 rst = 1'b0;
        send(C1_PT);
        in_valid = 1'b0;
        wait_out();
        chk("arst_next_ct", out_data, C1_CT);
        wait_idle();

        // Randomized blocks under a random key and random out_ready
        expand({$urandom, $urandom, $urandom, $urandom, 128'h0}, 4, 10, 1'b0);
        or_mode = 2;
        h0 = hs_cnt;
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send({$urandom, $urandom, $urandom, $urandom});
            in_valid = 1'b0;
        end
        wait_idle();
        chk("rand_delivered", 128'(hs_cnt - h0), 128'(25));

`ifdef AES_CTRL_ABORT_EN
        expand(C1_KEY, 4, 10, 1'b0);
        or_mode = 1;
        send(C1_PT);
        in_valid = 1'b0;
        wait_age(3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_in_ready", 128'(in_ready), 128'(1));
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        h0 = hs_cnt;
        repeat (15) @(negedge clk);
        chk("abort_no_output", 128'(hs_cnt - h0), 128'(0));
        send(C1_PT);
        in_valid = 1'b0;
        wait_out();
        chk("abort_next_ct", out_data, C1_CT);
        wait_idle();

        or_mode = 0;
        send(C1_PT);
        in_valid = 1'b0;
        wait_out();
        h0 = hs_cnt;
        abort = 1'b1;
        or_mode = 1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done_dropped", 128'(hs_cnt - h0), 128'(0));
        chk("abort_done_out_valid", 128'(out_valid), 128'(0));

        a0 = acc_cnt;
        abort = 1'b1;
        in_valid = 1'b1;
        in_data = C1_PT;
        @(posedge clk); #1;
        chk("abort_idle_accept", 128'(acc_cnt - a0), 128'(1));
        @(negedge clk);
        abort = 1'b0;
        in_valid = 1'b0;
        wait_idle();
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
